vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive side of the on-board VGA link: monitors a VGA stream (active-low HS/VS plus 4-bit RGB, one pixel per clk) and locks to its frame timing.
- Point-samples one pixel per 64x64 tile and writes it as an 8-bit value into the tile memory, at the same address map the VGA generator reads (bit7 = 1, col[3:0], row[2:0]).
- Used for loopback self-test of the display path and for frame capture.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BACKPORCH, 48, clk cycles from the HS rising edge (end of sync) to the first active pixel
- V_BACKPORCH, 33, HS rising edges counted after the VS rising edge before the first active line
- TILE_LOG2, 6, tile size is 2^TILE_LOG2 pixels square
- SAMPLE_OFF, 16, x/y offset inside a tile of the sampled pixel; must be < 2^TILE_LOG2

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- VGA_R  in  4  red
- VGA_G  in  4  green
- VGA_B  in  4  blue
- VGA_HS_I  in  1  horizontal sync, active-low
- VGA_VS_I  in  1  vertical sync, active-low
- waddr  out  8  tile memory write address {1'b1, col[3:0], row[2:0]}
- wdata  out  8  {R[3:1], G[3:1], B[3:2]}
- we  out  1  write strobe, one cycle per sample
- locked  out  1  a complete, well-formed frame has been seen since the last error/reset
- frame_done  out  1  one-cycle pulse after the last active line of a frame
- frame_err  out  1  one-cycle pulse on a malformed frame
- frame_cnt  out  8  count of good frames, wraps at 255 -> 0

Behaviour:
- Reset (reset == 0 at a clk edge): all outputs 0, FSM in WAIT_VS, all counters 0, input registers loaded with HS = VS = 1.
- Input stage:
  - All inputs are registered once (stage 1).
  - Edge detect compares stage 1 against a stage 2 copy of HS/VS.
  - Fall = 1 -> 0, rise = 0 -> 1.
- FSM states: WAIT_VS, VSYNC, VBP, LINE_WAIT, HBP, ACTIVE.
  - WAIT_VS: on VS fall -> VSYNC.
  - VSYNC: on VS rise -> VBP; line counter cleared.
  - VBP: count HS rises; on the V_BACKPORCH-th rise -> HBP with hcnt = 0, y = 0.
  - LINE_WAIT: on HS rise -> HBP with hcnt = 0.
  - HBP: hcnt increments; when hcnt == H_BACKPORCH-1 -> ACTIVE with x = 0.
  - ACTIVE: x increments per clk; when x == H_ACTIVE-1, y increments.
    - If the new y == V_ACTIVE -> WAIT_VS, pulse frame_done, frame_cnt += 1, set locked.
    - Otherwise -> LINE_WAIT.
- Sampling:
  - In ACTIVE, when x[TILE_LOG2-1:0] == SAMPLE_OFF and y[TILE_LOG2-1:0] == SAMPLE_OFF, capture that pixel.
  - Write it on the next clk: we = 1, waddr = {1'b1, x[9:6], y[8:6]}, wdata as packed above.
  - Latency from the pixel at the inputs to we is 2 clk.
  - Defaults give 10 cols x 8 rows = 80 writes per frame. Addresses run 0x80..0xCF for cols 0..9.
- Errors: frame_err pulses, locked clears, FSM -> VSYNC, and frame_cnt holds, when either of these occurs:
  - VS fall while in VBP, LINE_WAIT, HBP or ACTIVE;
  - HS fall while in HBP or ACTIVE (line too short).
- frame_done and frame_err never assert in the same cycle. An error detected in the final ACTIVE cycle takes priority.
- we is never asserted in WAIT_VS, VSYNC or VBP. A pending write still completes on the cycle after an error.
- frame_cnt wraps 255 -> 0 without setting frame_err.
- Reset asserted mid-frame: everything returns to WAIT_VS on that edge. The first frame after reset is captured only if a full VS pulse is seen after reset.

Decomposition:
- Package vga_pkg: timing constants (H_ACTIVE, V_ACTIVE, porches, TILE_LOG2), FSM state enum type, and a pack_rgb function (12 -> 8 bit).
- Sub-module sync_edge: a 2-stage register plus rise/fall detect. Instantiated once each for HS and VS.

Test Plan:
- Drive a standard 640x480 stream (800 clk/line, 525 lines, HS low 96, VS low 2, porches 48/33), tile (c,r) colour R=c, G=r, B=3. Required: exactly 80 we pulses per frame, waddr 0x80+{c,r}, wdata = {c[3:1], r[3:1], 2'b00}; frame_done once per frame; locked = 1 after frame 1.
- Same stream, check timing: the we for tile (0,0) occurs exactly 2 clk after the pixel x=16, y=16 is on the inputs.
- Assert a VS fall at line 200 of ACTIVE. Required: frame_err pulse, locked = 0, frame_cnt unchanged, no writes until the next VBP completes; the following good frame re-sets locked.
- Shorten one line (HS falls at x=300). Required: frame_err, locked = 0, FSM returns to VSYNC.
- Run 256 good frames. Required: frame_cnt goes 255 -> 0, frame_err is never asserted.
- Pull reset low for 1 clk at mid-frame (y=240). Required: all outputs 0 the next cycle; no we until after the next VS pulse plus back porch.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture path: default timing, FSM encoding
// and the 12-bit to 8-bit colour packing used by the tile memory.
package vga_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_H_BACKPORCH = 48;
    localparam int DEF_V_BACKPORCH = 33;
    localparam int DEF_TILE_LOG2   = 6;
    localparam int DEF_SAMPLE_OFF  = 16;

    typedef enum logic [2:0] {
        WAIT_VS   = 3'd0,
        VSYNC     = 3'd1,
        VBP       = 3'd2,
        LINE_WAIT = 3'd3,
        HBP       = 3'd4,
        ACTIVE    = 3'd5
    } state_t;

    // {R,G,B} 4:4:4 in, keeps the top 3/3/2 bits
    function automatic logic [7:0] pack_rgb(input logic [11:0] rgb);
        return {rgb[11:9], rgb[7:5], rgb[3:2]};
    endfunction

endpackage

// File: rtl/vga_capture_sync_edge.sv
// Two-stage register on one sync line with rise/fall detect between stages.
// Both stages idle high so a released reset never looks like a falling edge.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q_p1;
    logic q_p2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_p1 <= 1'b1;
            q_p2 <= 1'b1;
        end else begin
            q_p1 <= d;
            q_p2 <= q_p1;
        end
    end

    assign rise = q_p1 & ~q_p2;
    assign fall = ~q_p1 & q_p2;

endmodule

// File: rtl/vga_capture.sv
// Locks to an incoming VGA stream and point-samples one pixel per tile into
// the tile memory, using the same address map the generator reads.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BACKPORCH = DEF_H_BACKPORCH,
    parameter int V_BACKPORCH = DEF_V_BACKPORCH,
    parameter int TILE_LOG2   = DEF_TILE_LOG2,
    parameter int SAMPLE_OFF  = DEF_SAMPLE_OFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] VGA_R,
    input  logic [3:0] VGA_G,
    input  logic [3:0] VGA_B,
    input  logic       VGA_HS_I,
    input  logic       VGA_VS_I,
    output logic [7:0] waddr,
    output logic [7:0] wdata,
    output logic       we,
    output logic       locked,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    localparam logic [TILE_LOG2-1:0] SOFF = TILE_LOG2'(SAMPLE_OFF);

    state_t      state;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb_p1;
    logic        hs_rise, hs_fall, vs_rise, vs_fall;
    logic        err;
    logic        sample;

    sync_edge u_hs (.clk(clk), .reset(reset), .d(VGA_HS_I), .rise(hs_rise), .fall(hs_fall));
    sync_edge u_vs (.clk(clk), .reset(reset), .d(VGA_VS_I), .rise(vs_rise), .fall(vs_fall));

    // stage 1: colour aligned with the registered sync edges
    always_ff @(posedge clk) begin
        rgb_p1 <= {VGA_R, VGA_G, VGA_B};
    end

    always_comb begin
        err = 1'b0;
        case (state)
            VBP, LINE_WAIT: err = vs_fall;
            HBP, ACTIVE:    err = vs_fall | hs_fall;
            default:        err = 1'b0;
        endcase
    end

    assign sample = (state == ACTIVE) && !err &&
                    (x[TILE_LOG2-1:0] == SOFF) && (y[TILE_LOG2-1:0] == SOFF);

    // stage 2: tile write and frame tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= WAIT_VS;
            hcnt       <= '0;
            vcnt       <= '0;
            x          <= '0;
            y          <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            we         <= sample;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (sample) begin
                waddr <= {1'b1, x[TILE_LOG2+3:TILE_LOG2], y[TILE_LOG2+2:TILE_LOG2]};
                wdata <= pack_rgb(rgb_p1);
            end
            if (err) begin
                state     <= VSYNC;
                frame_err <= 1'b1;
                locked    <= 1'b0;
            end else begin
                case (state)
                    WAIT_VS: if (vs_fall) state <= VSYNC;
                    VSYNC: begin
                        if (vs_rise) begin
                            state <= VBP;
                            vcnt  <= '0;
                        end
                    end
                    VBP: begin
                        if (hs_rise) begin
                            if (vcnt == 10'(V_BACKPORCH - 1)) begin
                                state <= HBP;
                                hcnt  <= '0;
                                y     <= '0;
                            end else begin
                                vcnt <= vcnt + 10'd1;
                            end
                        end
                    end
                    LINE_WAIT: begin
                        if (hs_rise) begin
                            state <= HBP;
                            hcnt  <= '0;
                        end
                    end
                    HBP: begin
                        hcnt <= hcnt + 10'd1;
                        if (hcnt == 10'(H_BACKPORCH - 1)) begin
                            state <= ACTIVE;
                            x     <= '0;
                        end
                    end
                    ACTIVE: begin
                        x <= x + 10'd1;
                        if (x == 10'(H_ACTIVE - 1)) begin
                            y <= y + 10'd1;
                            if (y == 10'(V_ACTIVE - 1)) begin
                                state      <= WAIT_VS;
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 8'd1;
                                locked     <= 1'b1;
                            end else begin
                                state <= LINE_WAIT;
                            end
                        end
                    end
                    default: state <= WAIT_VS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down raster (20x8 active,
// 2x2 tiles) so hundreds of frames fit in a short run.
module tb_vga_capture;

    localparam int H_ACT = 20;
    localparam int V_ACT = 8;
    localparam int H_BP  = 2;
    localparam int V_BP  = 1;
    localparam int TILE  = 1;
    localparam int SOFF  = 1;
    // HS low, then HS high for H_BP+1 cycles before pixel 0 (one cycle is the
    // input register), active pixels, one front-porch cycle
    localparam int HSW   = 1;
    localparam int HPRE  = H_BP + 1;
    localparam int LINE  = HSW + HPRE + H_ACT + 1;
    localparam int WPF   = (H_ACT >> TILE) * (V_ACT >> TILE);

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS_I, VGA_VS_I;
    logic [7:0] waddr, wdata, frame_cnt;
    logic       we, locked, frame_done, frame_err;

    int nchecks = 0;
    int nerrors = 0;
    int exp_cnt = 0;
    int mark    = 0;
    int cyc     = 0;
    int n_we    = 0;
    int n_done  = 0;
    int n_err   = 0;
    logic [15:0] wq[$];
    int          wcyc[$];

    vga_capture #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_BACKPORCH(H_BP),
        .V_BACKPORCH(V_BP), .TILE_LOG2(TILE), .SAMPLE_OFF(SOFF)
    ) dut (
        .clk(clk), .reset(reset),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS_I(VGA_HS_I), .VGA_VS_I(VGA_VS_I),
        .waddr(waddr), .wdata(wdata), .we(we),
        .locked(locked), .frame_done(frame_done), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            n_we = n_we + 1;
            wq.push_back({waddr, wdata});
            wcyc.push_back(cyc);
        end
        if (frame_done === 1'b1) n_done = n_done + 1;
        if (frame_err === 1'b1) n_err = n_err + 1;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            VGA_HS_I = 1'b1;
            VGA_VS_I = 1'b1;
            {VGA_R, VGA_G, VGA_B} = '0;
        end
        #1;
    endtask

    // row < 0: blank line; cut_x/vs_x >= 0: HS/VS forced low from that pixel on
    task automatic drive_line(input bit vs, input int row, input int cut_x, input int vs_x);
        int px;
        for (int i = 0; i < LINE; i++) begin
            @(negedge clk);
            px = i - HSW - HPRE;
            VGA_HS_I = (i >= HSW);
            VGA_VS_I = vs;
            if (row >= 0 && px >= 0 && px < H_ACT) begin
                VGA_R = 4'(px >> TILE);
                VGA_G = 4'(row >> TILE);
                VGA_B = 4'd3;
                if (row == SOFF && px == SOFF) mark = cyc;
            end else begin
                {VGA_R, VGA_G, VGA_B} = '0;
            end
            if (cut_x >= 0 && px >= cut_x) VGA_HS_I = 1'b0;
            if (vs_x >= 0 && px >= vs_x) VGA_VS_I = 1'b0;
        end
    endtask

    // a VS glitch ends the frame after that line, VS still low
    task automatic drive_frame(input int cut_row, input int cut_x, input int vs_row, input int vs_x);
        drive_line(1'b0, -1, -1, -1);
        for (int r = 0; r < V_ACT; r++) begin
            drive_line(1'b1, r, (r == cut_row) ? cut_x : -1, (r == vs_row) ? vs_x : -1);
            if (r == vs_row) break;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        VGA_HS_I = 1'b1;
        VGA_VS_I = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        VGA_HS_I = 1'b1;
        VGA_VS_I = 1'b1;
        {VGA_R, VGA_G, VGA_B} = '0;
        repeat (3) @(negedge clk);
        #1;
        nchecks++; if (we !== 1'b0) begin nerrors++; $display("FAIL reset_we got %b want 0", we); end
        nchecks++; if (waddr !== 8'h00) begin nerrors++; $display("FAIL reset_waddr got %h want 00", waddr); end
        nchecks++; if (wdata !== 8'h00) begin nerrors++; $display("FAIL reset_wdata got %h want 00", wdata); end
        nchecks++; if (locked !== 1'b0) begin nerrors++; $display("FAIL reset_locked got %b want 0", locked); end
        nchecks++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            nerrors++; $display("FAIL reset_pulses got done=%b err=%b want 0 0", frame_done, frame_err);
        end
        nchecks++; if (frame_cnt !== 8'h00) begin nerrors++; $display("FAIL reset_cnt got %0d want 0", frame_cnt); end
        reset = 1'b1;
        exp_cnt = 0;
        idle(4);
    endtask

    task automatic test_capture();
        int b, bd, be, k;
        logic [3:0] cc, rr;
        logic [15:0] exp_w;
        for (int f = 0; f < 2; f++) begin
            b = n_we; bd = n_done; be = n_err;
            drive_frame(-1, -1, -1, -1);
            idle(3);
            exp_cnt++;
            nchecks++; if (n_we - b !== WPF) begin nerrors++; $display("FAIL cap_writes frame %0d got %0d want %0d", f, n_we - b, WPF); end
            nchecks++; if (n_done - bd !== 1) begin nerrors++; $display("FAIL cap_done frame %0d got %0d want 1", f, n_done - bd); end
            nchecks++; if (n_err - be !== 0) begin nerrors++; $display("FAIL cap_err frame %0d got %0d want 0", f, n_err - be); end
            nchecks++; if (locked !== 1'b1) begin nerrors++; $display("FAIL cap_locked frame %0d got %b want 1", f, locked); end
            nchecks++; if (frame_cnt !== 8'(exp_cnt)) begin nerrors++; $display("FAIL cap_cnt got %0d want %0d", frame_cnt, exp_cnt); end
            k = b;
            for (int r = 0; r < (V_ACT >> TILE); r++) begin
                for (int c = 0; c < (H_ACT >> TILE); c++) begin
                    cc = 4'(c);
                    rr = 4'(r);
                    exp_w = {1'b1, cc, rr[2:0], cc[3:1], rr[3:1], 2'b00};
                    nchecks++;
                    if (k >= wq.size()) begin
                        nerrors++; $display("FAIL cap_tile c%0d r%0d got none want %h", c, r, exp_w);
                    end else if (wq[k] !== exp_w) begin
                        nerrors++; $display("FAIL cap_tile c%0d r%0d got %h want %h", c, r, wq[k], exp_w);
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic test_timing();
        int b;
        b = n_we;
        drive_frame(-1, -1, -1, -1);
        idle(3);
        exp_cnt++;
        nchecks++;
        if (n_we - b < 2) begin
            nerrors++; $display("FAIL timing_writes got %0d want >=2", n_we - b);
        end else begin
            if (wcyc[b] - mark !== 2) begin nerrors++; $display("FAIL timing_tile00 got %0d clk want 2", wcyc[b] - mark); end
            nchecks++;
            if (wcyc[b+1] - mark !== 4) begin nerrors++; $display("FAIL timing_tile10 got %0d clk want 4", wcyc[b+1] - mark); end
            nchecks++;
            if (wq[b][15:8] !== 8'h80) begin nerrors++; $display("FAIL timing_addr got %h want 80", wq[b][15:8]); end
        end
    endtask

    task automatic test_vs_error();
        int b, bd, be;
        b = n_we; bd = n_done; be = n_err;
        drive_frame(-1, -1, V_ACT / 2, 6);
        #1;
        nchecks++; if (n_err - be !== 1) begin nerrors++; $display("FAIL vserr_pulse got %0d want 1", n_err - be); end
        nchecks++; if (n_done - bd !== 0) begin nerrors++; $display("FAIL vserr_done got %0d want 0", n_done - bd); end
        nchecks++; if (locked !== 1'b0) begin nerrors++; $display("FAIL vserr_locked got %b want 0", locked); end
        nchecks++; if (frame_cnt !== 8'(exp_cnt)) begin nerrors++; $display("FAIL vserr_cnt got %0d want %0d", frame_cnt, exp_cnt); end
        nchecks++; if (n_we - b !== 20) begin nerrors++; $display("FAIL vserr_writes got %0d want 20", n_we - b); end
        b = n_we; be = n_err;
        drive_frame(-1, -1, -1, -1);
        idle(3);
        exp_cnt++;
        nchecks++; if (n_we - b !== WPF) begin nerrors++; $display("FAIL vserr_recover_writes got %0d want %0d", n_we - b, WPF); end
        nchecks++; if (locked !== 1'b1) begin nerrors++; $display("FAIL vserr_relock got %b want 1", locked); end
        nchecks++; if (n_err - be !== 0) begin nerrors++; $display("FAIL vserr_recover_err got %0d want 0", n_err - be); end
        nchecks++; if (frame_cnt !== 8'(exp_cnt)) begin nerrors++; $display("FAIL vserr_recover_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_short_line();
        int b, bd, be;
        b = n_we; bd = n_done; be = n_err;
        drive_frame(2, 10, -1, -1);
        idle(3);
        nchecks++; if (n_err - be !== 1) begin nerrors++; $display("FAIL short_pulse got %0d want 1", n_err - be); end
        nchecks++; if (locked !== 1'b0) begin nerrors++; $display("FAIL short_locked got %b want 0", locked); end
        nchecks++; if (n_we - b !== 10) begin nerrors++; $display("FAIL short_writes got %0d want 10", n_we - b); end
        nchecks++; if (n_done - bd !== 0) begin nerrors++; $display("FAIL short_done got %0d want 0", n_done - bd); end
        nchecks++; if (frame_cnt !== 8'(exp_cnt)) begin nerrors++; $display("FAIL short_cnt got %0d want %0d", frame_cnt, exp_cnt); end
        b = n_we;
        drive_frame(-1, -1, -1, -1);
        idle(3);
        exp_cnt++;
        nchecks++; if (n_we - b !== WPF) begin nerrors++; $display("FAIL short_recover_writes got %0d want %0d", n_we - b, WPF); end
        nchecks++; if (locked !== 1'b1) begin nerrors++; $display("FAIL short_relock got %b want 1", locked); end
    endtask

    task automatic test_reset_mid();
        int b;
        drive_line(1'b0, -1, -1, -1);
        for (int r = 0; r < V_ACT / 2; r++) drive_line(1'b1, r, -1, -1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        nchecks++; if (locked !== 1'b0 || frame_cnt !== 8'h00) begin
            nerrors++; $display("FAIL midrst_state got locked=%b cnt=%0d want 0 0", locked, frame_cnt);
        end
        nchecks++; if (we !== 1'b0 || waddr !== 8'h00 || wdata !== 8'h00) begin
            nerrors++; $display("FAIL midrst_write got we=%b a=%h d=%h want 0 00 00", we, waddr, wdata);
        end
        nchecks++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            nerrors++; $display("FAIL midrst_pulses got done=%b err=%b want 0 0", frame_done, frame_err);
        end
        reset = 1'b1;
        exp_cnt = 0;
        b = n_we;
        for (int r = V_ACT / 2; r < V_ACT; r++) drive_line(1'b1, r, -1, -1);
        idle(3);
        nchecks++; if (n_we - b !== 0) begin nerrors++; $display("FAIL midrst_tail_writes got %0d want 0", n_we - b); end
        b = n_we;
        drive_frame(-1, -1, -1, -1);
        idle(3);
        exp_cnt++;
        nchecks++; if (n_we - b !== WPF) begin nerrors++; $display("FAIL midrst_next_writes got %0d want %0d", n_we - b, WPF); end
        nchecks++; if (frame_cnt !== 8'(exp_cnt) || locked !== 1'b1) begin
            nerrors++; $display("FAIL midrst_next got cnt=%0d locked=%b want %0d 1", frame_cnt, locked, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        int b, bd, be;
        pulse_reset(2);
        idle(3);
        b = n_we; bd = n_done; be = n_err;
        for (int f = 0; f < 255; f++) begin
            drive_frame(-1, -1, -1, -1);
            exp_cnt++;
        end
        idle(3);
        nchecks++; if (frame_cnt !== 8'd255) begin nerrors++; $display("FAIL wrap_255 got %0d want 255", frame_cnt); end
        drive_frame(-1, -1, -1, -1);
        exp_cnt++;
        idle(3);
        nchecks++; if (frame_cnt !== 8'(exp_cnt)) begin nerrors++; $display("FAIL wrap_0 got %0d want %0d", frame_cnt, 8'(exp_cnt)); end
        nchecks++; if (n_err - be !== 0) begin nerrors++; $display("FAIL wrap_err got %0d want 0", n_err - be); end
        nchecks++; if (n_done - bd !== 256) begin nerrors++; $display("FAIL wrap_done got %0d want 256", n_done - bd); end
        nchecks++; if (n_we - b !== 256 * WPF) begin nerrors++; $display("FAIL wrap_writes got %0d want %0d", n_we - b, 256 * WPF); end
        nchecks++; if (locked !== 1'b1) begin nerrors++; $display("FAIL wrap_locked got %b want 1", locked); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_timing();
        test_vs_error();
        test_short_line();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
